// File: rtl/intr_ctrl.sv
// ---------------------------------------------------------------------------
// intr_ctrl - interrupt sequencer for the 5-stage MIPS pipeline core.
//
// Latches rising edges of the level interrupt requests into a pending
// register, masks them, picks the lowest-index unmasked source and walks the
// pipeline through interrupt entry (stall IF, flush ID, wait for the back end
// to drain, redirect to the handler vector) and ERET return (redirect to EPC).
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   irq                : level interrupt requests (already synchronous)
//   im_wen, im_din     : interrupt mask write port
//   id_pc, id_valid    : PC / valid of the instruction in ID
//   id_branch          : ID holds a branch/jump (no interrupt this cycle)
//   eret               : valid ERET decoded in ID
//   drain_done         : EXE/MEM/WB hold no uncommitted instruction
//   if_stall, flush_id : pipeline freeze / ID invalidate
//   redirect, redirect_pc : PC load request and target
//   epc, cause         : saved return PC, one-hot source being serviced
//   in_isr, ie         : handler running, global interrupt enable
//   pending            : latched pending requests
//   state              : FSM state for debug
// ---------------------------------------------------------------------------
module intr_ctrl #(
    parameter int                 NUM_IRQ     = 4,
    parameter logic [31:0]        VECTOR_ADDR = 32'h0000_0004,
    parameter logic [NUM_IRQ-1:0] IM_RESET    = '1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               im_wen,
    input  logic [NUM_IRQ-1:0] im_din,
    input  logic [31:0]        id_pc,
    input  logic               id_valid,
    input  logic               id_branch,
    input  logic               eret,
    input  logic               drain_done,
    output logic               if_stall,
    output logic               flush_id,
    output logic               redirect,
    output logic [31:0]        redirect_pc,
    output logic [31:0]        epc,
    output logic [NUM_IRQ-1:0] cause,
    output logic               in_isr,
    output logic               ie,
    output logic [NUM_IRQ-1:0] pending,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAIN  = 3'd1,
        VECTOR = 3'd2,
        ISR    = 3'd3,
        RET    = 3'd4
    } state_t;

    localparam logic [NUM_IRQ-1:0] ONE = NUM_IRQ'(1);

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [NUM_IRQ-1:0] im_q, im_d;
    logic [NUM_IRQ-1:0] cause_q, cause_d;
    logic [31:0]        epc_q, epc_d;
    logic               ie_q, ie_d;

    logic [NUM_IRQ-1:0] masked;
    logic [NUM_IRQ-1:0] sel;
    logic [NUM_IRQ-1:0] rise;
    logic               take;

    assign masked = pending_q & im_q;
    // x & -x isolates the lowest set bit: lowest index has highest priority.
    assign sel    = masked & (~masked + ONE);
    assign rise   = irq & ~irq_prev_q;
    assign take   = (state_q == IDLE) & ie_q & (|masked) & id_valid
                    & ~id_branch & ~eret;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = DRAIN;
            DRAIN:   if (drain_done) state_d = VECTOR;
            VECTOR:  state_d = ISR;
            ISR:     if (eret) state_d = RET;
            RET:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- output decode ----------------
    always_comb begin
        if_stall    = 1'b0;
        flush_id    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        in_isr      = 1'b0;
        case (state_q)
            DRAIN: begin
                if_stall = 1'b1;
                flush_id = 1'b1;
            end
            VECTOR: begin
                redirect    = 1'b1;
                redirect_pc = VECTOR_ADDR;
                flush_id    = 1'b1;
            end
            ISR: begin
                in_isr   = 1'b1;
                flush_id = eret;
            end
            RET: begin
                redirect    = 1'b1;
                redirect_pc = epc_q;
            end
            default: ;
        endcase
    end

    // ---------------- interrupt bookkeeping ----------------
    always_comb begin
        // A new rise on the bit being cleared wins over the clear.
        pending_d = (pending_q & ~(take ? sel : '0)) | rise;
        im_d      = im_wen ? im_din : im_q;
        epc_d     = epc_q;
        cause_d   = cause_q;
        ie_d      = ie_q;
        if (take) begin
            epc_d   = id_pc;
            cause_d = sel;
            ie_d    = 1'b0;
        end else if (state_q == RET) begin
            cause_d = '0;
            ie_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q  <= '0;
            irq_prev_q <= '0;
            im_q       <= IM_RESET;
            epc_q      <= 32'h0;
            cause_q    <= '0;
            ie_q       <= 1'b1;
        end else begin
            pending_q  <= pending_d;
            irq_prev_q <= irq;
            im_q       <= im_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
            ie_q       <= ie_d;
        end
    end

    assign epc     = epc_q;
    assign cause   = cause_q;
    assign ie      = ie_q;
    assign pending = pending_q;
    assign state   = state_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_intr_ctrl - directed self-checking bench for intr_ctrl.
// Inputs change 1 ns after the rising edge; outputs are compared there too,
// with a further 1 ns settle when a combinational input was just changed.
// ---------------------------------------------------------------------------
module tb_intr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq;
    logic        im_wen;
    logic [3:0]  im_din;
    logic [31:0] id_pc;
    logic        id_valid;
    logic        id_branch;
    logic        eret;
    logic        drain_done;
    logic        if_stall;
    logic        flush_id;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] epc;
    logic [3:0]  cause;
    logic        in_isr;
    logic        ie;
    logic [3:0]  pending;
    logic [2:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    intr_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .irq         (irq),
        .im_wen      (im_wen),
        .im_din      (im_din),
        .id_pc       (id_pc),
        .id_valid    (id_valid),
        .id_branch   (id_branch),
        .eret        (eret),
        .drain_done  (drain_done),
        .if_stall    (if_stall),
        .flush_id    (flush_id),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .epc         (epc),
        .cause       (cause),
        .in_isr      (in_isr),
        .ie          (ie),
        .pending     (pending),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From DRAIN: VECTOR, ISR, ERET -> RET, back to IDLE.
    task automatic run_to_idle(input logic [31:0] exp_epc);
        drain_done = 1'b1;
        tick();
        check_eq("rti_vector_state", state, 3'd2);
        drain_done = 1'b0;
        tick();
        check_eq("rti_isr_state", state, 3'd3);
        eret = 1'b1;
        tick();
        check_eq("rti_ret_pc", redirect_pc, exp_epc);
        eret = 1'b0;
        tick();
        check_eq("rti_idle_state", state, 3'd0);
    endtask

    initial begin
        rst = 1'b1; irq = '0; im_wen = 1'b0; im_din = '0; id_pc = '0;
        id_valid = 1'b0; id_branch = 1'b0; eret = 1'b0; drain_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // ---- reset state ----
        check_eq("rst_state",    state,    3'd0);
        check_eq("rst_ie",       ie,       1'b1);
        check_eq("rst_pending",  pending,  4'b0000);
        check_eq("rst_redirect", redirect, 1'b0);
        check_eq("rst_if_stall", if_stall, 1'b0);
        check_eq("rst_epc",      epc,      32'h0);
        check_eq("rst_cause",    cause,    4'b0000);

        // ---- single interrupt, full entry/return ----
        id_pc = 32'h40; id_valid = 1'b1; irq = 4'b0100;
        tick();
        check_eq("s1_pending", pending, 4'b0100);
        check_eq("s1_idle",    state,   3'd0);
        tick();
        check_eq("s1_drain",    state,    3'd1);
        check_eq("s1_if_stall", if_stall, 1'b1);
        check_eq("s1_flush",    flush_id, 1'b1);
        check_eq("s1_ie",       ie,       1'b0);
        tick();
        check_eq("s1_drain2",   state,    3'd1);
        check_eq("s1_stall2",   if_stall, 1'b1);
        drain_done = 1'b1;
        tick();
        check_eq("s1_vec_state", state,       3'd2);
        check_eq("s1_vec_redir", redirect,    1'b1);
        check_eq("s1_vec_pc",    redirect_pc, 32'h4);
        check_eq("s1_vec_flush", flush_id,    1'b1);
        drain_done = 1'b0;
        tick();
        check_eq("s1_in_isr",  in_isr,   1'b1);
        check_eq("s1_isr_ie",  ie,       1'b0);
        check_eq("s1_epc",     epc,      32'h40);
        check_eq("s1_cause",   cause,    4'b0100);
        check_eq("s1_pend_clr", pending, 4'b0000);
        check_eq("s1_no_redir", redirect, 1'b0);
        irq = 4'b0000;
        eret = 1'b1;
        #1;
        check_eq("s1_eret_flush", flush_id, 1'b1);
        tick();
        eret = 1'b0;
        check_eq("s1_ret_state", state,       3'd4);
        check_eq("s1_ret_redir", redirect,    1'b1);
        check_eq("s1_ret_pc",    redirect_pc, 32'h40);
        tick();
        check_eq("s1_back_idle", state, 3'd0);
        check_eq("s1_ie_back",   ie,    1'b1);
        check_eq("s1_cause_clr", cause, 4'b0000);

        // ---- two simultaneous requests, priority, retake after RET ----
        id_pc = 32'h100; irq = 4'b1010;
        tick();
        check_eq("s2_pending", pending, 4'b1010);
        tick();
        check_eq("s2_cause",   cause,   4'b0010);
        check_eq("s2_left",    pending, 4'b1000);
        check_eq("s2_epc",     epc,     32'h100);
        irq = 4'b0000;
        drain_done = 1'b1;
        tick();
        drain_done = 1'b0;
        tick();
        eret = 1'b1;
        tick();
        eret = 1'b0;
        check_eq("s2_ret_pc", redirect_pc, 32'h100);
        id_pc = 32'h200;
        tick();
        check_eq("s2_idle", state,   3'd0);
        check_eq("s2_ie",   ie,      1'b1);
        check_eq("s2_pend", pending, 4'b1000);
        tick();
        check_eq("s2_retake_state", state, 3'd1);
        check_eq("s2_retake_cause", cause, 4'b1000);
        check_eq("s2_retake_epc",   epc,   32'h200);
        run_to_idle(32'h200);

        // ---- branch in ID blocks take ----
        id_pc = 32'h300; id_branch = 1'b1; irq = 4'b0001;
        tick();
        check_eq("s3_pending", pending, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("s3_hold_idle", state, 3'd0);
        end
        id_branch = 1'b0; id_pc = 32'h304;
        tick();
        check_eq("s3_take",  state, 3'd1);
        check_eq("s3_epc",   epc,   32'h304);
        check_eq("s3_cause", cause, 4'b0001);
        irq = 4'b0000;
        run_to_idle(32'h304);

        // ---- fully masked request, then unmask ----
        im_wen = 1'b1; im_din = 4'b0000;
        tick();
        im_wen = 1'b0; irq = 4'b0010;
        tick();
        tick();
        tick();
        check_eq("s4_masked_idle", state,   3'd0);
        check_eq("s4_masked_pend", pending, 4'b0010);
        im_wen = 1'b1; im_din = 4'b0010;
        tick();
        im_wen = 1'b0;
        check_eq("s4_still_idle", state, 3'd0);
        tick();
        check_eq("s4_take",  state, 3'd1);
        check_eq("s4_cause", cause, 4'b0010);
        // Mask change while draining must not disturb the selection.
        im_wen = 1'b1; im_din = 4'b1111;
        tick();
        im_wen = 1'b0;
        check_eq("s4_drain_hold",  state, 3'd1);
        check_eq("s4_cause_keep",  cause, 4'b0010);
        run_to_idle(32'h304);

        // ---- reset in the middle of DRAIN ----
        irq = 4'b0100;
        tick();
        tick();
        check_eq("s5_drain", state, 3'd1);
        irq = 4'b0101;
        tick();
        check_eq("s5_pend", pending, 4'b0001);
        rst = 1'b1;
        tick();
        check_eq("s5_rst_state",   state,    3'd0);
        check_eq("s5_rst_pending", pending,  4'b0000);
        check_eq("s5_rst_stall",   if_stall, 1'b0);
        check_eq("s5_rst_ie",      ie,       1'b1);
        rst = 1'b0;
        irq = 4'b0000;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
